// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: bundle of the two requester ports, the SDRAM master port and arbiter status
// master: arbiter view (drives SDRAM strobes, port completions, status)
// slave:  environment view (drives requests and SDRAM responses)
interface sdram_port_arbiter_if #(
    parameter int W      = 16,
    parameter int ADDR_W = 25
);
    logic              m0_read, m0_write, m0_done;
    logic [ADDR_W-1:0] m0_address;
    logic [W-1:0]      m0_writedata, m0_readdata;
    logic              m1_read, m1_write, m1_done;
    logic [ADDR_W-1:0] m1_address;
    logic [W-1:0]      m1_writedata, m1_readdata;
    logic              s_read, s_write, s_readdatavalid, s_waitrequest;
    logic [ADDR_W-1:0] s_address;
    logic [W-1:0]      s_writedata, s_readdata;
    logic              grant, busy, timeout_err;
    modport master (
        input  m0_read, m0_write, m0_address, m0_writedata,
        input  m1_read, m1_write, m1_address, m1_writedata,
        input  s_readdata, s_readdatavalid, s_waitrequest,
        output m0_readdata, m0_done, m1_readdata, m1_done,
        output s_read, s_write, s_address, s_writedata,
        output grant, busy, timeout_err
    );
    modport slave (
        output m0_read, m0_write, m0_address, m0_writedata,
        output m1_read, m1_write, m1_address, m1_writedata,
        output s_readdata, s_readdatavalid, s_waitrequest,
        input  m0_readdata, m0_done, m1_readdata, m1_done,
        input  s_read, s_write, s_address, s_writedata,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin serialiser of two word ports onto one SDRAM master, one access at a time
// Ports: clk (rising edge), rst (async, active-high),
//        bus (master modport): m0/m1 request ports in, s_* SDRAM master out, grant/busy/timeout_err status.
module sdram_port_arbiter #(
    parameter int W       = 16,
    parameter int ADDR_W  = 25,
    parameter int WR_LAT  = 9,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    sdram_port_arbiter_if.master bus
);
    localparam int CW = $clog2(WR_LAT > TIMEOUT ? WR_LAT : TIMEOUT) + 1;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant, op_wr, req0, req1, pick, pick_wr;
    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;
    // on a tie the port not served last wins; a lone requester always wins
    assign pick    = req0 && req1 ? ~last_grant : req1;
    assign pick_wr = pick ? bus.m1_write : bus.m0_write;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            last_grant      <= 1'b1;
            op_wr           <= 1'b0;
            bus.grant       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.s_read      <= 1'b0;
            bus.s_write     <= 1'b0;
            bus.s_address   <= '0;
            bus.s_writedata <= '0;
            bus.m0_readdata <= '0;
            bus.m1_readdata <= '0;
            bus.m0_done     <= 1'b0;
            bus.m1_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    bus.grant       <= pick;
                    op_wr           <= pick_wr;
                    bus.s_write     <= pick_wr;
                    bus.s_read      <= ~pick_wr;
                    bus.s_address   <= pick ? bus.m1_address : bus.m0_address;
                    bus.s_writedata <= pick ? bus.m1_writedata : bus.m0_writedata;
                    bus.busy        <= 1'b1;
                    state           <= ISSUE;
                end
                ISSUE: if (!bus.s_waitrequest) begin
                    bus.s_read  <= 1'b0;
                    bus.s_write <= 1'b0;
                    cnt         <= op_wr ? CW'(WR_LAT - 1) : '0;
                    state       <= op_wr ? WAIT_WR : WAIT_RD;
                end
                // the last counted cycle is TIMEOUT-1 after acceptance, so DONE lands TIMEOUT cycles after it
                WAIT_RD: if (bus.s_readdatavalid || cnt == CW'(TIMEOUT - 2)) begin
                    if (bus.grant) bus.m1_readdata <= bus.s_readdatavalid ? bus.s_readdata : '0;
                    else bus.m0_readdata <= bus.s_readdatavalid ? bus.s_readdata : '0;
                    bus.timeout_err <= bus.timeout_err | ~bus.s_readdatavalid;
                    bus.m0_done     <= ~bus.grant;
                    bus.m1_done     <= bus.grant;
                    state           <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT_WR: if (cnt == '0) begin
                    bus.m0_done <= ~bus.grant;
                    bus.m1_done <= bus.grant;
                    state       <= DONE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    bus.m0_done <= 1'b0;
                    bus.m1_done <= 1'b0;
                    bus.busy    <= 1'b0;
                    last_grant  <= bus.grant;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single SDRAM word port used by the KNN system. Port 0 is the training/input loader (writes). Port 1 is the KNN inference engine (reads). The block serialises their accesses onto one SDRAM master interface, one outstanding transaction at a time, with round-robin fairness, write-recovery timing and a read timeout.

Parameters:
W, 16, data word width
ADDR_W, 25, address width
WR_LAT, 9, cycles the SDRAM is busy after a write is accepted (>=1)
TIMEOUT, 64, max cycles waiting for s_readdatavalid before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
m0_read  in  1  port 0 read request, held until m0_done
m0_write  in  1  port 0 write request, held until m0_done
m0_address  in  ADDR_W  port 0 address, stable while requesting
m0_writedata  in  W  port 0 write data
m0_readdata  out  W  port 0 read data, valid with m0_done
m0_done  out  1  one-cycle completion pulse, port 0
m1_read, m1_write, m1_address, m1_writedata, m1_readdata, m1_done  same as port 0, for port 1
s_read  out  1  SDRAM read strobe
s_write  out  1  SDRAM write strobe
s_address  out  ADDR_W  SDRAM address
s_writedata  out  W  SDRAM write data
s_readdata  in  W  SDRAM read data
s_readdatavalid  in  1  s_readdata valid this cycle
s_waitrequest  in  1  SDRAM cannot accept the strobe this cycle
grant  out  1  index of the port currently being served
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky flag, set on any read timeout

Behaviour:
- Reset (async): state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie; counters 0.
- Request = mX_read | mX_write. If both are high, the transaction is treated as a write.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE.
- IDLE:
  - Only one port requesting: grant it.
  - Both requesting: grant the port != last_grant.
  - On grant: register grant, s_address, s_writedata and the op; go to ISSUE on the next edge.
- ISSUE:
  - s_read or s_write is high; address and data are stable.
  - s_waitrequest=1: hold the strobe and stay in ISSUE.
  - s_waitrequest=0: the strobe is accepted that edge. Drop the strobe. Go to WAIT_RD (read) or WAIT_WR (write, counter loaded with WR_LAT-1).
- WAIT_RD:
  - s_readdatavalid=1: capture s_readdata into the granted port's mX_readdata; go to DONE.
  - Counter reaching TIMEOUT-1 without valid: mX_readdata=0, set timeout_err, go to DONE.
- WAIT_WR: decrement the counter; at 0 go to DONE.
- DONE:
  - mX_done=1 for exactly one cycle on the granted port only.
  - last_grant<=grant; return to IDLE.
  - The requester drops its request on the clock edge where it samples mX_done.
- Latency:
  - Read: request sampled in IDLE at edge k → strobe visible in cycle k+1 (ISSUE) → mX_done one cycle after the edge that samples s_readdatavalid.
  - Write with no waitrequest: mX_done cycle = strobe cycle + WR_LAT + 1.
- Minimum gap: one IDLE cycle between transactions. A request still high in DONE is not re-granted in that same cycle.
- mX_readdata holds its value until that port's next read completes.
- s_readdatavalid outside WAIT_RD is ignored.
- s_readdata is sampled only in WAIT_RD.
- Request dropped by a port mid-transaction: the transaction completes anyway and mX_done still pulses.
- Reset mid-transaction: abort immediately, no mX_done; timeout_err cleared.

Test Plan:
- m1 read, addr 0x40; readdatavalid asserted 3 cycles after the strobe with data 0x1234 → s_read 1 cycle, m1_readdata=0x1234, m1_done single pulse, m0_done stays 0.
- m0 write, addr 0x10, data 0xBEEF, WR_LAT=9 → s_write 1 cycle with 0x10/0xBEEF, m0_done exactly 10 cycles after the strobe.
- Both ports requesting reads continuously from reset → grant order 0,1,0,1; each done pulses on its own port only; one IDLE cycle between transactions.
- s_waitrequest high for 4 cycles during m0 read → s_read held 5 cycles with stable address, then normal completion.
- m1 read, no s_readdatavalid, TIMEOUT=64 → m1_done 64 cycles after acceptance, m1_readdata=0, timeout_err=1 and stays 1 until rst.
- rst asserted during WAIT_WR → all outputs 0 asynchronously, no done pulse; after release, a pending m1 request is served first (last_grant reset).
